// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: pointer sizing, parameter checks and access decode.
package fifo_pkg;

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int unsigned ptr_bits(input int unsigned ptr_width);
    return ptr_width + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  // Encoded as {read_accepted, write_accepted}.
  typedef enum logic [1:0] {
    OpNone  = 2'b00,
    OpWrite = 2'b01,
    OpRead  = 2'b10,
    OpBoth  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_dp_ram.sv
// FIFO storage: DEPTH x DATA_WIDTH array, synchronous write, asynchronous read. Not reset.
module fifo_dp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 4
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_en,
  input  logic [PTR_WIDTH-1:0]  i_w_addr,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  input  logic [PTR_WIDTH-1:0]  i_r_addr,
  output logic [DATA_WIDTH-1:0] o_r_data
);

  localparam int unsigned DEPTH = 1 << PTR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_w_clk) begin
    if (i_w_en) begin
      r_mem[i_w_addr] <= i_w_data;
    end
  end

  assign o_r_data = r_mem[i_r_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with pointer control, level, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = 14,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW = ptr_bits(PTR_WIDTH);
  localparam logic [PW-1:0] LP_AF = PW'(AF_LEVEL);
  localparam logic [PW-1:0] LP_AE = PW'(AE_LEVEL);

  if (!is_pow2(DEPTH) || (DEPTH != (1 << PTR_WIDTH))) begin : g_depth_check
    $error("sync_fifo_ctrl: DEPTH must equal 2**PTR_WIDTH");
  end

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [PW-1:0]         w_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rd_data;
  fifo_op_e              w_op;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                    (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]);
  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_wr_acc = w_en & ~w_full;
  assign w_rd_acc = r_en & ~w_empty;
  assign w_op     = fifo_op_e'({w_rd_acc, w_wr_acc});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      unique case (w_op)
        OpNone:  begin end
        OpWrite: r_wr_ptr <= r_wr_ptr + 1'b1;
        OpRead:  r_rd_ptr <= r_rd_ptr + 1'b1;
        OpBoth: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      endcase
      r_overflow  <= r_overflow | (w_en & w_full);
      // A read that coincides with a write into an empty FIFO is not an underflow.
      r_underflow <= r_underflow | (r_en & w_empty & ~w_en);
    end
  end

  fifo_dp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_ram (
    .i_w_clk  (clk),
    .i_w_en   (w_wr_acc),
    .i_w_addr (r_wr_ptr[PTR_WIDTH-1:0]),
    .i_w_data (data_in),
    .i_r_addr (r_rd_ptr[PTR_WIDTH-1:0]),
    .o_r_data (w_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out   = w_rd_data;
  assign data_valid = ~w_empty;
`else
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_data_out <= w_rd_data;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
`endif

  assign full         = w_full;
  assign empty        = w_empty;
  assign level        = w_level;
  assign almost_full  = (w_level >= LP_AF);
  assign almost_empty = (w_level <= LP_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (DW=8, PW=4, AF=14, AE=2); honours SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       w_en;
  logic [7:0] data_in;
  logic       r_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  int n_total = 0;
  int n_bad   = 0;

  sync_fifo_ctrl #(
    .DATA_WIDTH (8),
    .PTR_WIDTH  (4),
    .DEPTH      (16),
    .AF_LEVEL   (14),
    .AE_LEVEL   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    w_en    = 1'b1;
    data_in = d;
    tick();
    w_en    = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_data", data_out, exp);
    chk("fwft_valid", data_valid, 1);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
`else
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("rd_data", data_out, exp);
    chk("rd_valid", data_valid, 1);
    tick();
    chk("rd_valid_drop", data_valid, 0);
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ae"}, almost_empty, 1);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_unf"}, underflow, 0);
    chk({tag, "_valid"}, data_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk({tag, "_dout"}, data_out, 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk_reset("rst");
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
    #2;
    chk_reset("por");
    tick();
    tick();
    rst = 1'b0;

    // 1: fill to full, then overflow.
    for (int i = 0; i < 16; i++) begin
      wr(8'(i + 1));
      chk("t1_level", level, i + 1);
      chk("t1_af", almost_full, (i + 1 >= 14) ? 1 : 0);
      chk("t1_ae", almost_empty, (i + 1 <= 2) ? 1 : 0);
      chk("t1_full", full, (i == 15) ? 1 : 0);
    end
    wr(8'hEE);
    chk("t1_ovf", overflow, 1);
    chk("t1_ovf_level", level, 16);

    // 2: drain in order, then underflow.
    for (int i = 0; i < 16; i++) begin
      do_read(8'(i + 1));
      chk("t2_level", level, 15 - i);
      chk("t2_empty", empty, (i == 15) ? 1 : 0);
    end
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("t2_unf", underflow, 1);
    chk("t2_unf_level", level, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("t2_unf_dout", data_out, 8'h10);
    chk("t2_unf_valid", data_valid, 0);
`endif

    // 3: half full, 40 cycles of simultaneous read+write (pointers wrap twice).
    for (int i = 0; i < 8; i++) wr(8'(8'h20 + i));
    for (int k = 0; k < 40; k++) begin
      w_en = 1'b1; r_en = 1'b1; data_in = 8'(8'h28 + k);
`ifdef SYNC_FIFO_FWFT_EN
      chk("t3_data", data_out, 8'h20 + k);
`endif
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      chk("t3_data", data_out, 8'h20 + k);
      chk("t3_valid", data_valid, 1);
`endif
      chk("t3_level", level, 8);
      chk("t3_flags", {full, empty, almost_full, almost_empty}, 4'b0000);
    end
    w_en = 1'b0; r_en = 1'b0;
    tick();
    chk("t3_level_end", level, 8);
    chk("t3_sticky", {overflow, underflow}, 2'b11);

    // 4a: full with read+write: only the read is taken.
    for (int i = 0; i < 8; i++) wr(8'(8'h50 + i));
    chk("t4_full", full, 1);
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h99;
`ifdef SYNC_FIFO_FWFT_EN
    chk("t4_full_data", data_out, 8'h48);
`endif
    tick();
    w_en = 1'b0; r_en = 1'b0;
    chk("t4_full_level", level, 15);
    chk("t4_full_flag", full, 0);
    chk("t4_full_ovf", overflow, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("t4_full_data", data_out, 8'h48);
`endif
    for (int j = 0; j < 15; j++) begin
      do_read((j < 7) ? 8'(8'h49 + j) : 8'(8'h50 + j - 7));
    end
    chk("t4_drained", empty, 1);

    // 4b: empty with read+write: only the write is taken, no underflow.
    do_reset();
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h77;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    chk("t4_empty_level", level, 1);
    chk("t4_empty_unf", underflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("t4_empty_valid", data_valid, 0);
`endif
    do_read(8'h77);

    // 5: asynchronous reset mid-burst at level 9 with overflow set.
    for (int i = 0; i < 16; i++) wr(8'(8'h60 + i));
    wr(8'hEE);
    for (int i = 0; i < 7; i++) do_read(8'(8'h60 + i));
    chk("t5_level", level, 9);
    chk("t5_ovf", overflow, 1);
    w_en = 1'b1; data_in = 8'hAB;
    #2;
    rst = 1'b1;
    #1;
    chk_reset("t5_async");
    tick();
    rst = 1'b0; w_en = 1'b0;
    chk("t5_discard", level, 0);
    wr(8'h3C);
    chk("t5_wr_level", level, 1);
    do_read(8'h3C);

`ifdef SYNC_FIFO_FWFT_EN
    // 6: fall-through presentation and pop.
    wr(8'hA5);
    chk("t6_data", data_out, 8'hA5);
    chk("t6_valid", data_valid, 1);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("t6_empty", empty, 1);
    chk("t6_valid_low", data_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
